// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display driver: digit count and the
// active-low {g,f,e,d,c,b,a} hex glyph table.
package display_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] HEX7SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_segment_output_driver_hex_to_seg7.sv
// Combinational nibble to active-low segment pattern lookup.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7SEG[nibble];

endmodule

// File: rtl/seven_segment_output_driver.sv
// Multiplexed 4-digit hex display driver with per-frame snapshot, ghost
// blanking, leading-zero blanking and a value-changed decimal-point flash.
module seven_segment_output_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int FLASH_CYCLES = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_for_output,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);
  localparam logic [1:0]    LAST_DIGIT = 2'(DIGITS - 1);

  logic [DW-1:0] div_cnt;
  logic [1:0]    digit_sel;
  logic [15:0]   shadow;
  logic [FW-1:0] flash_cnt;
  logic          first;

  logic          div_wrap;
  logic          snap;
  logic [3:0]    nibble;
  logic [6:0]    seg_next;
  logic [3:0]    lz_mask;
  logic [3:0]    an_next;

  assign div_wrap = (div_cnt == DIV_LAST);
  // The first post-reset cycle also snapshots so the display lights up
  // without waiting for a full frame.
  assign snap     = first | (div_wrap & (digit_sel == LAST_DIGIT));

  always_comb begin
    nibble = shadow[3:0];
    case (digit_sel)
      2'd0: nibble = shadow[3:0];
      2'd1: nibble = shadow[7:4];
      2'd2: nibble = shadow[11:8];
      2'd3: nibble = shadow[15:12];
      default: nibble = shadow[3:0];
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg_n  (seg_next)
  );

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (shadow[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] & (shadow[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] & (shadow[7:4] == 4'h0);
  end

  always_comb begin
    an_next = 4'hF;
    if ((div_cnt >= BLANK_END) && !(blank_lz && lz_mask[digit_sel]))
      an_next = ~(4'b0001 << digit_sel);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_sel <= '0;
      shadow    <= '0;
      flash_cnt <= '0;
      first     <= 1'b1;
    end else begin
      first   <= 1'b0;
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap)
        digit_sel <= digit_sel + 1'b1;
      if (snap)
        shadow <= data_for_output;
      if (snap && (data_for_output != shadow))
        flash_cnt <= FLASH_LOAD;
      else if (flash_cnt != '0)
        flash_cnt <= flash_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      an_n        <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (first) begin
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
        an_n  <= 4'hF;
      end else begin
        seg_n <= seg_next;
        dp_n  <= !((digit_sel == 2'd0) && (flash_cnt != '0));
        an_n  <= an_next;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_output_driver.sv
// Randomized scoreboard bench for seven_segment_output_driver using a
// time-indexed reference model of the scan, snapshot and flash rules.
module tb_seven_segment_output_driver;

  localparam int S     = 4;
  localparam int B     = 1;
  localparam int F     = 10;
  localparam int FRAME = 4 * S;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_for_output = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];

  logic [6:0] ref_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seven_segment_output_driver #(
    .SCAN_DIV     (S),
    .BLANK_CYCLES (B),
    .FLASH_CYCLES (F)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .data_for_output (data_for_output),
    .blank_lz        (blank_lz),
    .seg_n           (seg_n),
    .dp_n            (dp_n),
    .an_n            (an_n),
    .frame_start     (frame_start)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // n = clock edges since reset release; the output after edge n reflects
  // the display state after n edges, plus whether edge n took a snapshot.
  function automatic logic is_snap(int n);
    return (n == 0) || ((n % FRAME) == FRAME - 1);
  endfunction

  function automatic logic [12:0] expect_at(int n, logic [15:0] sh, int lc, logic lz);
    int         sel;
    int         div;
    int         fl;
    logic [3:0] nib;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
    fs = is_snap(n);
    if (n == 0) return {7'h7F, 1'b1, 4'hF, fs};
    div = n % S;
    sel = (n / S) % 4;
    fl  = F - (n - 1 - lc);
    if (fl < 0) fl = 0;
    nib = 4'(sh >> (4 * sel));
    seg = ref_seg[nib];
    dp  = !((sel == 0) && (fl > 0));
    an  = 4'hF;
    if ((div >= B) && !(lz && (sel > 0) && ((sh >> (4 * sel)) == 16'h0)))
      an = ~(4'b0001 << sel);
    return {seg, dp, an, fs};
  endfunction

  int          m_edges = 0;
  logic [15:0] m_shadow = 16'h0000;
  int          m_last_change = -1000000;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_edges       = 0;
      m_shadow      = 16'h0000;
      m_last_change = -1000000;
      exp_q.delete();
    end else begin
      exp_q.push_back(expect_at(m_edges, m_shadow, m_last_change, blank_lz));
      if (is_snap(m_edges)) begin
        if (data_for_output != m_shadow) m_last_change = m_edges;
        m_shadow = data_for_output;
      end
      m_edges++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [12:0] got;
  logic [12:0] want;
  int          cyc = 0;

  always @(negedge clock) begin
    cyc++;
    got = {seg_n, dp_n, an_n, frame_start};
    if (reset) begin
      total++;
      if (got !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
        bad++;
        $display("FAIL reset_dark cycle=%0d got=%h want=%h", cyc, got, {7'h7F, 1'b1, 4'hF, 1'b0});
      end
    end else if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL outputs cycle=%0d got seg=%h dp=%b an=%h fs=%b want seg=%h dp=%b an=%h fs=%b",
                 cyc, got[12:6], got[5], got[4:1], got[0], want[12:6], want[5], want[4:1], want[0]);
      end
      total++;
      if ($countones(~an_n) > 1) begin
        bad++;
        $display("FAIL anode_onehot cycle=%0d got an=%h want at most one active", cyc, an_n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hold(input logic [15:0] value, input int n);
    data_for_output = value;
    step(n);
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic async_reset_check();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({seg_n, an_n, dp_n, frame_start} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got seg=%h an=%h dp=%b fs=%b want seg=7f an=f dp=1 fs=0",
               seg_n, an_n, dp_n, frame_start);
    end
    step(2);
    release_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    data_for_output = 16'h1234;
    release_reset();

    // reset mid-scan with a value loaded, then one clean frame of 1234
    step(FRAME + 6);
    async_reset_check();
    step(2 * FRAME);

    // change mid-frame: rest of frame keeps ABCD, then 0001 with flash
    hold(16'hABCD, 2 * FRAME + 5);
    hold(16'h0001, 2 * FRAME);

    // leading-zero blanking
    blank_lz = 1'b1;
    hold(16'h0050, 2 * FRAME);
    hold(16'h0000, 2 * FRAME);
    hold(16'h0300, 2 * FRAME);
    blank_lz = 1'b0;
    hold(16'h0000, 2 * FRAME);

    // unchanged value: no flash after the first capture
    hold(16'h7777, 4 * FRAME);

    // reloads two frames apart
    hold(16'h0001, 2 * FRAME);
    hold(16'h0002, 2 * FRAME);
    hold(16'h0003, 3 * FRAME);

    // random stress over 1000 frames
    for (int i = 0; i < 1000 * FRAME; i++) begin
      data_for_output = 16'($urandom);
      if ((i % 64) == 0) blank_lz = 1'($urandom_range(0, 1));
      step(1);
    end

    // random held values so leading-zero and flash paths see steady data
    for (int i = 0; i < 20; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      hold(16'($urandom_range(0, 255)) << (4 * $urandom_range(0, 2)), FRAME * $urandom_range(1, 3));
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
